// File: rtl/temporizador_regressivo.sv
// Countdown timer 0..VALOR_MAX with pause/resume and an alarm at zero.
// Inputs are edge-detected; the binary count feeds the 2-digit display decoder.
module temporizador_regressivo #(
    parameter int CICLOS_POR_TICK = 50_000_000,
    parameter int VALOR_MAX       = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       carregar,
    input  logic [7:0] valor_inicial,
    input  logic       iniciar,
    input  logic       pausar,
    output logic [7:0] contagem,
    output logic       alarme,
    output logic [1:0] estado
);

    localparam int PW = $clog2(CICLOS_POR_TICK);
    localparam logic [PW-1:0] PRESC_FIM = PW'(CICLOS_POR_TICK - 1);
    localparam logic [PW-1:0] PRESC_UM  = PW'(1);
    localparam logic [7:0]    LIMITE    = 8'(VALOR_MAX);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSADO  = 2'd2,
        FIM      = 2'd3
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [7:0]    contagem_q, contagem_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          alarme_q, alarme_d;

    // bit order everywhere: {carregar, pausar, iniciar}
    logic [2:0] amostra_q;
    logic [2:0] anterior_q;
    logic [2:0] evento;
    logic       ev_carregar;
    logic       ev_pausar;
    logic       ev_iniciar;
    logic       fim_seg;
    logic [7:0] valor_sat;

    // Loading the live level on reset suppresses an event for inputs
    // already high when reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            amostra_q  <= {carregar, pausar, iniciar};
            anterior_q <= {carregar, pausar, iniciar};
        end else begin
            amostra_q  <= {carregar, pausar, iniciar};
            anterior_q <= amostra_q;
        end
    end

    assign evento      = amostra_q & ~anterior_q;
    assign ev_carregar = evento[2];
    assign ev_pausar   = evento[1];
    assign ev_iniciar  = evento[0];

    assign fim_seg   = (presc_q == PRESC_FIM);
    assign valor_sat = (valor_inicial > LIMITE) ? LIMITE
                                                : valor_inicial;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            contagem_q <= '0;
            presc_q    <= '0;
            alarme_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            contagem_q <= contagem_d;
            presc_q    <= presc_d;
            alarme_q   <= alarme_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        contagem_d = contagem_q;
        presc_d    = presc_q;
        alarme_d   = alarme_q;

        if (ev_carregar) begin
            contagem_d = valor_sat;
            estado_d   = OCIOSO;
            presc_d    = '0;
            alarme_d   = 1'b0;
        end else begin
            unique case (estado_q)
                OCIOSO: begin
                    if (!ev_pausar && ev_iniciar &&
                        contagem_q != 8'd0) begin
                        estado_d = CONTANDO;
                        presc_d  = '0;
                    end
                end
                CONTANDO: begin
                    // a pause on the tick cycle freezes the prescaler
                    if (ev_pausar) begin
                        estado_d = PAUSADO;
                    end else if (fim_seg) begin
                        presc_d = '0;
                        if (contagem_q <= 8'd1) begin
                            contagem_d = 8'd0;
                            estado_d   = FIM;
                            alarme_d   = 1'b1;
                        end else begin
                            contagem_d = contagem_q - 8'd1;
                        end
                    end else begin
                        presc_d = presc_q + PRESC_UM;
                    end
                end
                PAUSADO: begin
                    if (!ev_pausar && ev_iniciar) begin
                        estado_d = CONTANDO;
                    end
                end
                FIM: begin
                    contagem_d = 8'd0;
                    alarme_d   = 1'b1;
                end
                default: begin
                    estado_d = OCIOSO;
                end
            endcase
        end
    end

    assign contagem = contagem_q;
    assign alarme   = alarme_q;
    assign estado   = estado_q;

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Directed bench for temporizador_regressivo with a 4-cycle tick.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_temporizador_regressivo;

    logic       clk = 1'b0;
    logic       reset;
    logic       carregar;
    logic [7:0] valor_inicial;
    logic       iniciar;
    logic       pausar;
    logic [7:0] contagem;
    logic       alarme;
    logic [1:0] estado;

    int checks   = 0;
    int failures = 0;

    temporizador_regressivo #(
        .CICLOS_POR_TICK(4),
        .VALOR_MAX(99)
    ) dut (
        .clk(clk),
        .reset(reset),
        .carregar(carregar),
        .valor_inicial(valor_inicial),
        .iniciar(iniciar),
        .pausar(pausar),
        .contagem(contagem),
        .alarme(alarme),
        .estado(estado)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs,
                         input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // raise at edge N, FSM acts at edge N+1; returns after N+1
    task automatic load(input logic [7:0] v);
        valor_inicial = v;
        carregar = 1'b1;
        tick();
        carregar = 1'b0;
        tick();
    endtask

    task automatic start();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        carregar = 1'b0;
        iniciar = 1'b0;
        pausar = 1'b0;
        valor_inicial = 8'd0;
        tick(2);
        reset = 1'b0;
        tick();
        check("rst_cont", contagem, 0);
        check("rst_est", estado, 0);
        check("rst_alm", alarme, 0);

        // 1: count 5 down to 0
        load(8'd5);
        check("t1_load", contagem, 5);
        check("t1_est0", estado, 0);
        start();
        check("t1_run", estado, 1);
        check("t1_c5", contagem, 5);
        for (int v = 4; v >= 0; v--) begin
            tick(3);
            check("t1_hold", contagem, v + 1);
            check("t1_est_run", estado, 1);
            tick();
            check("t1_step", contagem, v);
        end
        check("t1_fim", estado, 3);
        check("t1_alm", alarme, 1);

        // 5b: iniciar in FIM is ignored
        start();
        tick(4);
        check("fim_est", estado, 3);
        check("fim_cont", contagem, 0);
        check("fim_alm", alarme, 1);

        // 2: saturation on load
        load(8'd150);
        check("t2_150", contagem, 99);
        check("t2_est", estado, 0);
        check("t2_alm", alarme, 0);
        load(8'd99);
        check("t2_99", contagem, 99);
        load(8'd255);
        check("t2_255", contagem, 99);
        load(8'd100);
        check("t2_100", contagem, 99);
        load(8'd0);
        check("t2_0", contagem, 0);

        // 4a: start with zero count is ignored
        start();
        tick(5);
        check("t4_zero_est", estado, 0);
        check("t4_zero_cnt", contagem, 0);

        // 3: pause two cycles into a second
        load(8'd10);
        start();
        tick(4);
        check("t3_dec", contagem, 9);
        tick();
        pausar = 1'b1;
        tick();
        pausar = 1'b0;
        tick();
        check("t3_paused", estado, 2);
        tick(20);
        check("t3_frz_cnt", contagem, 9);
        check("t3_frz_est", estado, 2);
        start();
        check("t3_resume", estado, 1);
        check("t3_r0", contagem, 9);
        tick();
        check("t3_r1", contagem, 9);
        tick();
        check("t3_r2", contagem, 8);

        // 4b: held iniciar yields a single event
        load(8'd3);
        iniciar = 1'b1;
        tick(2);
        check("t4_run", estado, 1);
        tick();
        pausar = 1'b1;
        tick();
        pausar = 1'b0;
        tick();
        check("t4_pause", estado, 2);
        tick(5);
        check("t4_held_est", estado, 2);
        check("t4_held_cnt", contagem, 3);
        iniciar = 1'b0;
        tick();

        // 5a: coincident events in CONTANDO, carregar wins
        start();
        check("t5_run", estado, 1);
        valor_inicial = 8'd7;
        carregar = 1'b1;
        pausar = 1'b1;
        iniciar = 1'b1;
        tick();
        carregar = 1'b0;
        pausar = 1'b0;
        iniciar = 1'b0;
        tick();
        check("t5_cont", contagem, 7);
        check("t5_est", estado, 0);
        check("t5_alm", alarme, 0);

        // 6: synchronous reset mid-count
        start();
        tick(4);
        check("t6_six", contagem, 6);
        tick();
        reset = 1'b1;
        tick();
        check("t6_rst_cnt", contagem, 0);
        check("t6_rst_est", estado, 0);
        iniciar = 1'b1;
        tick();
        reset = 1'b0;
        tick(2);
        load(8'd5);
        tick(3);
        check("t6_nostart", estado, 0);
        check("t6_cnt", contagem, 5);
        iniciar = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
